// File: rtl/lfsr_rng_server_if.sv
// Handshake bundle between the random-number server and its requesters.
// The server takes the slave modport; requesters (or a bench) take master.
interface lfsr_rng_server_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] rnd_ready;
  logic [NUM_REQ-1:0] gnt;
  logic               rnd_valid;
  logic [31:0]        rnd;

  modport master (
    output req,
    output rnd_ready,
    input  gnt,
    input  rnd_valid,
    input  rnd
  );

  modport slave (
    input  req,
    input  rnd_ready,
    output gnt,
    output rnd_valid,
    output rnd
  );
endinterface

// File: rtl/lfsr_rng_server.sv
// Shared 32-bit LFSR server: round-robin grants with a valid/ready handshake,
// seeding with zero-seed substitution, and a warm-up run after reset/reseed.
module lfsr_rng_server #(
  parameter int unsigned NUM_REQ       = 4,
  parameter logic [31:0] SEED          = 32'd12403652,
  parameter int unsigned WARMUP_CYCLES = 32
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [31:0]        seed_i,
  input  logic               seed_load_i,
  output logic               busy_o,
  lfsr_rng_server_if.slave   rng
);

  localparam int unsigned CNT_W = (WARMUP_CYCLES == 0) ? 1 : $clog2(WARMUP_CYCLES + 1);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(WARMUP_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_REQ-1:0] GNT_ONE  = NUM_REQ'(1);

  localparam logic [1:0] ST_WARMUP = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_SERVE  = 2'd2;
  localparam logic [1:0] ST_START  = (WARMUP_CYCLES == 0) ? ST_IDLE : ST_WARMUP;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;

  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic               xfer;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic fb;
    fb = s[27] ^ s[23] ^ s[19] ^ s[18] ^ s[15] ^ s[11] ^ s[7] ^ s[4] ^ s[1];
    return {s[30:0], fb};
  endfunction

  // Index arithmetic modulo NUM_REQ, which need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                input int unsigned    off);
    int unsigned sum;
    sum = 32'(p) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && rng.req[wrap_add(rr_ptr_q, i)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(rr_ptr_q, i);
      end
    end
  end

  assign xfer = (state_q == ST_SERVE) && rng.rnd_ready[gidx_q] && rng.req[gidx_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    gidx_d   = gidx_q;

    case (state_q)
      ST_WARMUP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          lfsr_d = lfsr_step(lfsr_q);
          cnt_d  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d   = GNT_ONE << pick_idx;
          gidx_d  = pick_idx;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (xfer) begin
          lfsr_d   = lfsr_step(lfsr_q);
          rr_ptr_d = wrap_add(gidx_q, 1);
          gnt_d    = '0;
          state_d  = ST_IDLE;
        end else if (!rng.req[gidx_q]) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Reseed overrides everything except the pointer advance of a same-cycle transfer.
    if (seed_load_i) begin
      state_d = ST_START;
      cnt_d   = CNT_INIT;
      lfsr_d  = (seed_i == 32'd0) ? SEED : seed_i;
      gnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_START;
      cnt_q    <= CNT_INIT;
      lfsr_q   <= SEED;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      gidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
    end
  end

  assign rng.gnt       = gnt_q;
  assign rng.rnd_valid = (state_q == ST_SERVE);
  assign rng.rnd       = (state_q == ST_SERVE) ? lfsr_q : 32'd0;
  assign busy_o        = (state_q == ST_WARMUP);

endmodule
